// File: rtl/dac_pkg.sv
// ============================================================================
// dac_pkg : shared types and constants for the DAC0832-style bus writer
// Rev 1.0
// ============================================================================
`default_nettype none

package dac_pkg;

    localparam int CH_W   = 3;
    localparam int DATA_W = 8;

    localparam int DEF_CLK_DIV     = 4;
    localparam int DEF_SETUP_TICKS = 1;
    localparam int DEF_WR_TICKS    = 2;
    localparam int DEF_NUM_CH      = 4;

    localparam int TICK_CNT_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_XFER  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        WRITE = ST_WRITE,
        HOLD  = ST_HOLD,
        XFER  = ST_XFER
    } state_t;

    function automatic logic ch_legal(input logic [CH_W-1:0] ch, input int num_ch);
        return ({1'b0, ch} < 4'(num_ch));
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_tick_gen.sv
// ============================================================================
// dac_tick_gen : CLK_DIV divider with synchronous clear, registered 1-clock tick
// Rev 1.0
// ============================================================================
`default_nettype none

module dac_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_q == LAST);
        if (clear) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/dac_writer.sv
// ============================================================================
// dac_writer : valid/ready sample words -> DAC0832-style parallel DAC bus
// Optional SIMUL_UPDATE_EN: transfer strobe only after the last channel. Rev 1.0
// ============================================================================
`default_nettype none

module dac_writer
    import dac_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int SETUP_TICKS = DEF_SETUP_TICKS,
    parameter int WR_TICKS    = DEF_WR_TICKS,
    parameter int NUM_CH      = DEF_NUM_CH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_channel,
    input  logic [DATA_W-1:0] in_data,
    output logic              dac_cs_n,
    output logic              dac_wr_n,
    output logic              dac_xfer_n,
    output logic [CH_W-1:0]   dac_address,
    output logic [DATA_W-1:0] dac_data,
    output logic              ch_err
);

    localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [TICK_CNT_W-1:0] SETUP_LD = TICK_CNT_W'(SETUP_TICKS);
    localparam logic [TICK_CNT_W-1:0] WR_LD    = TICK_CNT_W'(WR_TICKS);

    state_t                  state_q, state_d;
    logic [TICK_CNT_W-1:0]   tcnt_q, tcnt_d;
    logic                    cs_n_q, cs_n_d;
    logic                    wr_n_q, wr_n_d;
    logic                    xfer_n_q, xfer_n_d;
    logic [CH_W-1:0]         addr_q, addr_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    ch_err_q, ch_err_d;
    logic                    in_ready_q, in_ready_d;

    logic accept;
    logic tick;
    logic phase_done;
    logic do_xfer;

    assign accept     = in_valid & in_ready_q;
    assign phase_done = tick && (tcnt_q == TICK_CNT_W'(1));

`ifdef SIMUL_UPDATE_EN
    assign do_xfer = (addr_q == LAST_CH);
`else
    assign do_xfer = 1'b1;
`endif

    // Divider restarts on every accepted word so phase lengths are exact.
    dac_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .clear (accept),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        cs_n_d   = cs_n_q;
        wr_n_d   = wr_n_q;
        xfer_n_d = xfer_n_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ch_err_d = 1'b0;

        if (tick && !phase_done && state_q != IDLE)
            tcnt_d = tcnt_q - 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ch_legal(in_channel, NUM_CH)) begin
                        state_d = SETUP;
                        tcnt_d  = SETUP_LD;
                        cs_n_d  = 1'b0;
                        addr_d  = in_channel;
                        data_d  = in_data;
                    end else begin
                        ch_err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (phase_done) begin
                    state_d = WRITE;
                    tcnt_d  = WR_LD;
                    wr_n_d  = 1'b0;
                end
            end
            WRITE: begin
                if (phase_done) begin
                    state_d = HOLD;
                    tcnt_d  = TICK_CNT_W'(1);
                    wr_n_d  = 1'b1;
                end
            end
            HOLD: begin
                if (phase_done) begin
                    cs_n_d = 1'b1;
                    if (do_xfer) begin
                        state_d  = XFER;
                        tcnt_d   = WR_LD;
                        xfer_n_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            XFER: begin
                if (phase_done) begin
                    state_d  = IDLE;
                    xfer_n_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                cs_n_d   = 1'b1;
                wr_n_d   = 1'b1;
                xfer_n_d = 1'b1;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tcnt_q     <= '0;
            cs_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            xfer_n_q   <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            ch_err_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            cs_n_q     <= cs_n_d;
            wr_n_q     <= wr_n_d;
            xfer_n_q   <= xfer_n_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ch_err_q   <= ch_err_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign dac_cs_n    = cs_n_q;
    assign dac_wr_n    = wr_n_q;
    assign dac_xfer_n  = xfer_n_q;
    assign dac_address = addr_q;
    assign dac_data    = data_q;
    assign ch_err      = ch_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_writer.sv
// ============================================================================
// tb_dac_writer : directed scoreboard bench for dac_writer (default parameters)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dac_writer;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_channel;
    logic [7:0] in_data;
    logic       dac_cs_n;
    logic       dac_wr_n;
    logic       dac_xfer_n;
    logic [2:0] dac_address;
    logic [7:0] dac_data;
    logic       ch_err;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] d;
    } item_t;

    item_t sb[$];
    item_t cur;
    int    total = 0;
    int    bad   = 0;

    dac_writer u_dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_channel  (in_channel),
        .in_data     (in_data),
        .dac_cs_n    (dac_cs_n),
        .dac_wr_n    (dac_wr_n),
        .dac_xfer_n  (dac_xfer_n),
        .dac_address (dac_address),
        .dac_data    (dac_data),
        .ch_err      (ch_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_last(input logic [2:0] ch);
`ifdef SIMUL_UPDATE_EN
        return (ch == 3'd3);
`else
        return 1'b1;
`endif
    endfunction

    task automatic drive(input logic [2:0] ch, input logic [7:0] d);
        @(negedge clock);
        in_valid   = 1'b1;
        in_channel = ch;
        in_data    = d;
        if (ch < 3'd4) sb.push_back('{ch: ch, d: d});
    endtask

    // Returns after the accepting posedge; waited = idle cycles before it.
    task automatic wait_accept(output int waited);
        logic r;
        bit   ok;
        ok     = 1'b0;
        waited = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            r = in_ready;
            @(posedge clock);
            if (r && in_valid) begin
                ok     = 1'b1;
                waited = i;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "FAIL accept_timeout observed=none expected=accept");
        end
    endtask

    // Checks the full strobe waveform of one legal transaction, clock 1 onward.
    task automatic expect_txn(input logic [2:0] ch, input bit chain,
                              input logic [2:0] nch, input logic [7:0] nd,
                              input int stop_at, output int waited);
        int  n;
        bit  last;
        wait_accept(waited);
        #1;
        if (chain) begin
            in_channel = nch;
            in_data    = nd;
            sb.push_back('{ch: nch, d: nd});
        end else begin
            in_valid = 1'b0;
        end
        last = is_last(ch);
        n    = last ? 25 : 17;
        for (int k = 1; k <= n; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) begin
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 32'd0, 32'd1);
                    cur = '0;
                end else begin
                    cur = sb.pop_front();
                end
            end
            check($sformatf("cs_n k=%0d", k),   dac_cs_n,   !(k >= 1 && k <= 16));
            check($sformatf("wr_n k=%0d", k),   dac_wr_n,   !(k >= 5 && k <= 12));
            check($sformatf("xfer_n k=%0d", k), dac_xfer_n, !(last && k >= 17 && k <= 24));
            check($sformatf("ready k=%0d", k),  in_ready,   (k >= n));
            check($sformatf("addr k=%0d", k),   dac_address, cur.ch);
            check($sformatf("data k=%0d", k),   dac_data,    cur.d);
            check($sformatf("ch_err k=%0d", k), ch_err,      1'b0);
            if (k == stop_at) return;
        end
    endtask

    initial begin
        int w;

        // 1: reset with random inputs
        reset      = 1'b0;
        in_valid   = 1'($urandom);
        in_channel = 3'($urandom);
        in_data    = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_valid   = 1'($urandom);
            in_channel = 3'($urandom);
            in_data    = 8'($urandom);
        end
        #1;
        check("rst cs_n",   dac_cs_n,    1'b1);
        check("rst wr_n",   dac_wr_n,    1'b1);
        check("rst xfer_n", dac_xfer_n,  1'b1);
        check("rst addr",   dac_address, 3'd0);
        check("rst data",   dac_data,    8'd0);
        check("rst ch_err", ch_err,      1'b0);
        check("rst ready",  in_ready,    1'b0);
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rel ready pre", in_ready, 1'b0);
        @(posedge clock);
        #1;
        check("rel ready post", in_ready, 1'b1);

        // 2: single write
        drive(3'd2, 8'hA5);
        expect_txn(3'd2, 1'b0, 3'd0, 8'd0, 0, w);

        // 3: back-to-back with in_valid held
        drive(3'd0, 8'h11);
        expect_txn(3'd0, 1'b1, 3'd3, 8'hEE, 0, w);
        expect_txn(3'd3, 1'b0, 3'd0, 8'd0, 0, w);
        check("b2b accept at 25", w, 0);

        // 4: illegal channel
        drive(3'd5, 8'h77);
        wait_accept(w);
        #1;
        in_valid = 1'b0;
        check("illegal ch_err", ch_err,   1'b1);
        check("illegal cs_n",   dac_cs_n, 1'b1);
        check("illegal ready",  in_ready, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("illegal ch_err k=%0d", k), ch_err,     1'b0);
            check($sformatf("illegal cs_n k=%0d", k),   dac_cs_n,   1'b1);
            check($sformatf("illegal wr_n k=%0d", k),   dac_wr_n,   1'b1);
            check($sformatf("illegal xfer_n k=%0d", k), dac_xfer_n, 1'b1);
            check($sformatf("illegal ready k=%0d", k),  in_ready,   1'b1);
        end

        // 5: channels 0..3 in order (update-together behaviour when enabled)
        for (int c = 0; c < 4; c++) begin
            drive(3'(c), 8'(8'h20 + c));
            expect_txn(3'(c), 1'b0, 3'd0, 8'd0, 0, w);
        end

        // 6: reset in the middle of the write strobe
        drive(3'd2, 8'h5A);
        expect_txn(3'd2, 1'b0, 3'd0, 8'd0, 8, w);
        reset = 1'b0;
        #1;
        check("midrst cs_n",   dac_cs_n,   1'b1);
        check("midrst wr_n",   dac_wr_n,   1'b1);
        check("midrst xfer_n", dac_xfer_n, 1'b1);
        check("midrst ready",  in_ready,   1'b0);
        check("midrst addr",   dac_address, 3'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst ready post", in_ready, 1'b1);
        drive(3'd1, 8'h3C);
        expect_txn(3'd1, 1'b0, 3'd0, 8'd0, 0, w);

        check("scoreboard drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
